// File: rtl/cordic_pkg.sv
// Shared types and constants for the quadrant sequencer around the
// 8-bit first-quadrant sin/cos CORDIC core.
package cordic_pkg;

    localparam int PHASE_W = 10;
    localparam int MAG_W   = 8;
    localparam int OUT_W   = 9;

    // Gain-compensated initial X of the core (documented for reference).
    localparam int K_INIT  = 155;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/cordic_quadrant_map.sv
// Quadrant sign/swap of the first-quadrant core result.
// Ports: q, core_cos, core_sin in; cos_o, sin_o signed 9-bit out.
module cordic_quadrant_map
    import cordic_pkg::*;
(
    input  quad_t              q,
    input  logic [MAG_W-1:0]   core_cos,
    input  logic [MAG_W-1:0]   core_sin,
    output logic [OUT_W-1:0]   cos_o,
    output logic [OUT_W-1:0]   sin_o
);

    logic [OUT_W-1:0] c;
    logic [OUT_W-1:0] s;

    assign c = {1'b0, core_cos};
    assign s = {1'b0, core_sin};

    // Magnitudes stay <= 255, so 9-bit negation never overflows.
    always_comb begin
        cos_o = c;
        sin_o = s;
        unique case (q)
            Q0: begin
                cos_o = c;
                sin_o = s;
            end
            Q1: begin
                cos_o = -s;
                sin_o = c;
            end
            Q2: begin
                cos_o = -c;
                sin_o = -s;
            end
            Q3: begin
                cos_o = s;
                sin_o = -c;
            end
        endcase
    end

endmodule

// File: rtl/cordic_quadrant_seq.sv
// Sequencer: phase in -> one core conversion -> signed cos/sin out.
// Ports: CLK, RESET (sync, active-low); IN_VALID/IN_READY/PHASE in
// handshake; OUT_VALID/OUT_READY/COS_OUT/SIN_OUT/ERR out handshake;
// CORE_ANGLE/CORE_RESET_N to core, CORE_HALT/CORE_COS/CORE_SIN from core.
module cordic_quadrant_seq
    import cordic_pkg::*;
#(
    parameter int RESET_CYCLES = 2,
    parameter int MIN_RUN      = 2,
    parameter int TIMEOUT      = 32
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [PHASE_W-1:0] PHASE,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [OUT_W-1:0]   COS_OUT,
    output logic [OUT_W-1:0]   SIN_OUT,
    output logic               ERR,
    output logic [MAG_W-1:0]   CORE_ANGLE,
    output logic               CORE_RESET_N,
    input  logic               CORE_HALT,
    input  logic [MAG_W-1:0]   CORE_COS,
    input  logic [MAG_W-1:0]   CORE_SIN
);

    localparam int CNT_W = $clog2(TIMEOUT + RESET_CYCLES + MIN_RUN) + 1;

    state_t           state;
    quad_t            q_r;
    logic [CNT_W-1:0] cnt;
    logic [OUT_W-1:0] map_cos;
    logic [OUT_W-1:0] map_sin;

    cordic_quadrant_map u_map (
        .q        (q_r),
        .core_cos (CORE_COS),
        .core_sin (CORE_SIN),
        .cos_o    (map_cos),
        .sin_o    (map_sin)
    );

    assign IN_READY = (state == IDLE);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state        <= IDLE;
            q_r          <= Q0;
            cnt          <= '0;
            OUT_VALID    <= 1'b0;
            COS_OUT      <= '0;
            SIN_OUT      <= '0;
            ERR          <= 1'b0;
            CORE_ANGLE   <= '0;
            CORE_RESET_N <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    CORE_RESET_N <= 1'b0;
                    if (IN_VALID) begin
                        q_r        <= quad_t'(PHASE[9:8]);
                        CORE_ANGLE <= PHASE[7:0];
                        cnt        <= '0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(RESET_CYCLES - 1)) begin
                        CORE_RESET_N <= 1'b1;
                        cnt          <= '0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    // HALT is checked first so it wins over the timeout.
                    if (cnt >= CNT_W'(MIN_RUN) && CORE_HALT) begin
                        COS_OUT      <= map_cos;
                        SIN_OUT      <= map_sin;
                        ERR          <= 1'b0;
                        OUT_VALID    <= 1'b1;
                        CORE_RESET_N <= 1'b0;
                        state        <= DONE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        COS_OUT      <= '0;
                        SIN_OUT      <= '0;
                        ERR          <= 1'b1;
                        OUT_VALID    <= 1'b1;
                        CORE_RESET_N <= 1'b0;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    CORE_RESET_N <= 1'b0;
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        ERR       <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_quadrant_seq.sv
// Self-checking bench for cordic_quadrant_seq with a cycle-counting
// behavioural core model and a quadrant/latency reference model.
module tb_cordic_quadrant_seq;

    localparam int RC = 2;
    localparam int MR = 2;
    localparam int TO = 32;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [9:0] PHASE = '0;
    logic       OUT_VALID;
    logic       OUT_READY = 1'b0;
    logic [8:0] COS_OUT;
    logic [8:0] SIN_OUT;
    logic       ERR;
    logic [7:0] CORE_ANGLE;
    logic       CORE_RESET_N;
    logic       CORE_HALT;
    logic [7:0] CORE_COS = '0;
    logic [7:0] CORE_SIN = '0;

    int nchk = 0;
    int nerr = 0;

    int halt_at = 1000;
    bit halt_stuck = 1'b0;
    int ccnt = 0;

    cordic_quadrant_seq #(
        .RESET_CYCLES (RC),
        .MIN_RUN      (MR),
        .TIMEOUT      (TO)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .IN_VALID     (IN_VALID),
        .IN_READY     (IN_READY),
        .PHASE        (PHASE),
        .OUT_VALID    (OUT_VALID),
        .OUT_READY    (OUT_READY),
        .COS_OUT      (COS_OUT),
        .SIN_OUT      (SIN_OUT),
        .ERR          (ERR),
        .CORE_ANGLE   (CORE_ANGLE),
        .CORE_RESET_N (CORE_RESET_N),
        .CORE_HALT    (CORE_HALT),
        .CORE_COS     (CORE_COS),
        .CORE_SIN     (CORE_SIN)
    );

    always #5 CLK = ~CLK;

    // Core model: counts cycles out of reset, HALT from cycle halt_at on.
    always @(posedge CLK) begin
        if (!CORE_RESET_N) ccnt <= 0;
        else ccnt <= ccnt + 1;
    end

    assign CORE_HALT = halt_stuck || (CORE_RESET_N && ccnt >= halt_at);

    task automatic check(input string tag, input int obs, input int exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic conv(input logic [9:0] ph, input int h, input bit stuck,
                        input int c, input int s, input int hold);
        int  q;
        int  ec;
        int  es;
        int  eh;
        int  elat;
        bit  eerr;
        int  n;
        bit  got;
        logic [8:0] hc;
        logic [8:0] hs;

        q = int'(ph[9:8]);
        case (q)
            0: begin ec = c;  es = s;  end
            1: begin ec = -s; es = c;  end
            2: begin ec = -c; es = -s; end
            default: begin ec = s; es = -c; end
        endcase
        eh = stuck ? 0 : h;
        eerr = (eh > TO - 1);
        elat = eerr ? 1 + RC + TO : 1 + RC + ((eh > MR) ? eh : MR) + 1;
        if (eerr) begin
            ec = 0;
            es = 0;
        end

        CORE_COS = 8'(c);
        CORE_SIN = 8'(s);
        halt_at = h;
        halt_stuck = stuck;
        check("in_ready_idle", int'(IN_READY), 1);
        IN_VALID = 1'b1;
        PHASE = ph;
        tick();
        IN_VALID = 1'b0;
        PHASE = 10'($urandom);

        n = 0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (CORE_RESET_N) check("angle", int'(CORE_ANGLE), int'(ph[7:0]));
            tick();
            n++;
            if (OUT_VALID) got = 1'b1;
        end
        check("out_valid_seen", int'(got), 1);
        check("latency", n + 1, elat);
        check("cos", int'($signed(COS_OUT)), ec);
        check("sin", int'($signed(SIN_OUT)), es);
        check("err", int'(ERR), int'(eerr));

        hc = COS_OUT;
        hs = SIN_OUT;
        IN_VALID = 1'b1;
        PHASE = 10'($urandom);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", int'(OUT_VALID), 1);
            check("hold_cos", int'(COS_OUT), int'(hc));
            check("hold_sin", int'(SIN_OUT), int'(hs));
            check("hold_in_ready", int'(IN_READY), 0);
            check("hold_core_rst", int'(CORE_RESET_N), 0);
        end
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        IN_VALID = 1'b0;
        halt_stuck = 1'b0;
        check("drain_valid", int'(OUT_VALID), 0);
        check("drain_in_ready", int'(IN_READY), 1);
    endtask

    initial begin
        int seen;

        RESET = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", int'(OUT_VALID), 0);
        check("rst_in_ready", int'(IN_READY), 1);
        check("rst_core_rst", int'(CORE_RESET_N), 0);
        check("rst_err", int'(ERR), 0);
        check("rst_cos", int'(COS_OUT), 0);
        check("rst_angle", int'(CORE_ANGLE), 0);
        RESET = 1'b1;
        tick();

        conv(10'h040, 9, 1'b0, 200, 60, 5);
        conv(10'h140, 9, 1'b0, 200, 60, 0);
        conv(10'h240, 9, 1'b0, 200, 60, 0);
        conv(10'h340, 9, 1'b0, 200, 60, 0);
        conv(10'h100, 9, 1'b0, 200, 60, 5);
        conv(10'h0C0, 0, 1'b1, 17, 250, 1);
        conv(10'h2AA, 1000, 1'b0, 90, 90, 2);
        conv(10'h1F0, 5, 1'b0, 33, 77, 0);
        conv(10'h3FF, 31, 1'b0, 255, 255, 0);
        conv(10'h000, 3, 1'b0, 255, 0, 0);

        for (int k = 0; k < 20; k++) begin
            conv(10'($urandom), int'($urandom_range(0, 40)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a conversion that would never finish.
        halt_at = 1000;
        IN_VALID = 1'b1;
        PHASE = 10'h155;
        tick();
        IN_VALID = 1'b0;
        repeat (6) tick();
        check("midrun_core_rst", int'(CORE_RESET_N), 1);
        RESET = 1'b0;
        tick();
        check("mr_out_valid", int'(OUT_VALID), 0);
        check("mr_core_rst", int'(CORE_RESET_N), 0);
        RESET = 1'b1;
        tick();
        check("mr_in_ready", int'(IN_READY), 1);
        seen = 0;
        repeat (40) begin
            tick();
            if (OUT_VALID) seen++;
        end
        check("mr_no_stale", seen, 0);

        conv(10'h240, 4, 1'b0, 10, 20, 1);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/cordic_quadrant_seq.md
Name: cordic_quadrant_seq

Overview:
- Front/back-end sequencer for the 8-bit first-quadrant sin/cos CORDIC core.
- Accepts a full-circle phase (1024 units = 360 deg) over a valid/ready handshake.
- Reduces the phase to a quadrant plus a first-quadrant angle (256 units = 90 deg) and runs one core conversion: hold core reset, release it, wait for its HALT.
- Applies quadrant sign/swap and presents signed 9-bit cos/sin with a valid/ready handshake.

Parameters:
- RESET_CYCLES, 2, cycles CORE_RESET_N is held low with the new angle stable before release (min 1).
- MIN_RUN, 2, cycles after release during which CORE_HALT is ignored (covers HALT propagation and the stale value).
- TIMEOUT, 32, max RUN cycles before the conversion is aborted with ERR.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset, synchronous, active-low.
- IN_VALID  in  1  PHASE valid.
- IN_READY  out  1  block can accept PHASE.
- PHASE  in  10  [9:8] quadrant, [7:0] angle within quadrant.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer takes result.
- COS_OUT  out  9  signed two's-complement cos, magnitude scale of the core.
- SIN_OUT  out  9  signed two's-complement sin.
- ERR  out  1  qualifies OUT_VALID: core timed out; COS_OUT/SIN_OUT are 0.
- CORE_ANGLE  out  8  to core IN_ANGLE.
- CORE_RESET_N  out  1  to core RESET_PULSE, active-low.
- CORE_HALT  in  1  from core HALT.
- CORE_COS  in  8  from core COS_THETA, unsigned.
- CORE_SIN  in  8  from core SIN_THETA, unsigned.

Behaviour:
- Reset (RESET=0 at posedge):
  - state=IDLE, OUT_VALID=0, COS_OUT=SIN_OUT=0, ERR=0, CORE_ANGLE=0, CORE_RESET_N=0, counter=0.
  - Applies from any state, including mid-conversion. A pending result is discarded.
- All outputs are registered. IN_READY = (state==IDLE), a decode of the state register.
- IDLE:
  - Core held in reset.
  - On IN_VALID: latch quadrant into q_r, set CORE_ANGLE<=PHASE[7:0], cnt<=0, go LOAD.
- LOAD:
  - CORE_RESET_N=0, CORE_ANGLE stable.
  - cnt increments; when cnt==RESET_CYCLES-1, set CORE_RESET_N<=1, cnt<=0, go RUN.
- RUN:
  - CORE_RESET_N=1, cnt increments each cycle.
  - If cnt>=MIN_RUN and CORE_HALT=1: capture mapped result, set OUT_VALID<=1, ERR<=0, go DONE.
  - Else if cnt==TIMEOUT-1: COS_OUT=SIN_OUT<=0, ERR<=1, OUT_VALID<=1, go DONE.
  - If HALT and timeout occur in the same cycle, HALT wins.
- DONE:
  - CORE_RESET_N<=0, so the core is parked in reset.
  - Outputs held stable until OUT_READY=1, then OUT_VALID<=0 and go IDLE.
  - IN_VALID is ignored outside IDLE. There is no result/input overlap: single entry.
- Quadrant map, with C={0,CORE_COS} and S={0,CORE_SIN} as 9-bit values:
  - q=0: cos=+C, sin=+S
  - q=1: cos=-S, sin=+C
  - q=2: cos=-C, sin=-S
  - q=3: cos=+S, sin=-C
  - Negation is 9-bit two's complement; -0 = 0. Range is -255..+255, no overflow.
- Angle wrap: PHASE=0x3FF is q3 angle 255. PHASE=0x000 follows 0x3FF with no special case.
- Latency: handshake at cycle 0 -> OUT_VALID at cycle 1+RESET_CYCLES+max(MIN_RUN, H)+1, where H is the RUN cycle at which the core first shows HALT.
- Throughput: one conversion per latency+1 cycles when OUT_READY is held high.
- CORE_ANGLE is never changed while CORE_RESET_N=1.

Decomposition:
- Package cordic_pkg:
  - PHASE_W=10, MAG_W=8, OUT_W=9.
  - Core gain constant K_INIT=155.
  - Quadrant typedef (Q0..Q3).
  - State enum: IDLE, LOAD, RUN, DONE.
- One combinational sub-module, cordic_quadrant_map: (q, CORE_COS, CORE_SIN) -> (cos, sin) signed 9-bit.
- Sequencer FSM, counter and output registers stay in the top module.

Test Plan:
- Bench core model returns CORE_COS=200, CORE_SIN=60 with HALT at RUN cycle 9. PHASE=0x040 -> CORE_ANGLE=0x40 held through LOAD/RUN; COS_OUT=+200, SIN_OUT=+60, ERR=0; OUT_VALID at cycle 1+2+9+1=13.
- PHASE=0x140 -> COS_OUT=9'h1C4 (-60), SIN_OUT=+200. PHASE=0x240 -> 9'h138 (-200), 9'h1C4 (-60). PHASE=0x340 -> +60, 9'h138 (-200).
- Back-pressure: OUT_READY=0 for 5 cycles with IN_VALID=1, PHASE=0x100 -> outputs stable, IN_READY=0, CORE_RESET_N=0. Second phase accepted only in the cycle after OUT_READY=1.
- HALT stuck high from the core: HALT ignored for RUN cnt<2; result captured at cnt=2, never in LOAD.
- Core never raises HALT -> after 32 RUN cycles OUT_VALID=1, ERR=1, COS_OUT=SIN_OUT=0; next conversion then succeeds with ERR=0.
- RESET=0 asserted mid-RUN -> next cycle state IDLE, OUT_VALID=0, CORE_RESET_N=0, IN_READY=1 after release; no stale result emitted.
